// File: rtl/mul_hilo_unit.sv
// mul_hilo_unit: sequencing and HI/LO result stage around an external
// combinational 16x16 signed multiplier. Operands are registered toward the
// multiplier, the product is given SETTLE_CYCLES cycles to settle, and then it
// is written into (or accumulated into) the 32-bit HI/LO pair.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start; CLR completes here without going busy
// ST_WAIT | operands driven, r_cnt counts settle cycles up to capture
module mul_hilo_unit #(
    parameter int SETTLE_CYCLES = 2,
    parameter bit ACC_EN        = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_mul_x,
    output logic [15:0] o_mul_y,
    output logic        o_mul_en,
    input  logic [31:0] i_mul_z,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_hi,
    output logic [15:0] o_lo,
    output logic        o_overflow,
    input  logic        i_ovf_clr
);

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_MADD = 2'b01;
    localparam logic [1:0] OP_MSUB = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    // Terminal count for the settle counter; legal SETTLE_CYCLES is 1..15.
    localparam logic [3:0] SETTLE_TC = 4'(SETTLE_CYCLES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [1:0]  r_op;
    logic [15:0] r_mul_x;
    logic [15:0] r_mul_y;
    logic        r_mul_en;
    logic        r_done;
    logic [31:0] r_acc;
    logic        r_ovf;

    logic [1:0]  w_eff_op;
    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic        w_add_ovf;
    logic        w_sub_ovf;
    logic        w_cnt_tc;

    // With accumulation disabled every captured op degenerates to MULT.
    assign w_eff_op  = ACC_EN ? r_op : OP_MULT;
    assign w_sum     = r_acc + i_mul_z;
    assign w_diff    = r_acc - i_mul_z;
    assign w_add_ovf = (r_acc[31] == i_mul_z[31]) && (w_sum[31]  != r_acc[31]);
    assign w_sub_ovf = (r_acc[31] != i_mul_z[31]) && (w_diff[31] != r_acc[31]);
    assign w_cnt_tc  = (r_cnt == SETTLE_TC);

    // Control FSM, operand registers and HI/LO accumulator in one process.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_op     <= OP_MULT;
            r_mul_x  <= 16'd0;
            r_mul_y  <= 16'd0;
            r_mul_en <= 1'b0;
            r_done   <= 1'b0;
            r_acc    <= 32'd0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Listed before the capture logic so a coincident overflow set wins.
            if (i_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_op == OP_CLR) begin
                            r_acc  <= 32'd0;
                            r_ovf  <= 1'b0;
                            r_done <= 1'b1;
                        end else begin
                            r_mul_x  <= i_a;
                            r_mul_y  <= i_b;
                            r_op     <= i_op;
                            r_cnt    <= 4'd1;
                            r_mul_en <= 1'b1;
                            r_state  <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_cnt_tc) begin
                        case (w_eff_op)
                            OP_MADD: begin
                                r_acc <= w_sum;
                                if (w_add_ovf) begin
                                    r_ovf <= 1'b1;
                                end
                            end
                            OP_MSUB: begin
                                r_acc <= w_diff;
                                if (w_sub_ovf) begin
                                    r_ovf <= 1'b1;
                                end
                            end
                            default: r_acc <= i_mul_z;
                        endcase
                        r_done   <= 1'b1;
                        r_mul_en <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_mul_x    = r_mul_x;
    assign o_mul_y    = r_mul_y;
    assign o_mul_en   = r_mul_en;
    assign o_busy     = (r_state == ST_WAIT);
    assign o_done     = r_done;
    assign o_hi       = r_acc[31:16];
    assign o_lo       = r_acc[15:0];
    assign o_overflow = r_ovf;

endmodule
